// File: rtl/alu64_dispatch_stage_if.sv
// Request/result handshake bundle for the 64-bit ALU dispatch stage.
// master drives requests and accepts results; slave is the stage itself.
interface alu64_dispatch_stage_if #(
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [63:0]      in_a;
    logic [63:0]      in_b;
    logic [2:0]       in_oper;
    logic [TAG_W-1:0] in_tag;

    logic             out_valid;
    logic             out_ready;
    logic [63:0]      out_sum;
    logic [2:0]       out_oper;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid,
        output in_a,
        output in_b,
        output in_oper,
        output in_tag,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_sum,
        input  out_oper,
        input  out_tag
    );

    modport slave (
        input  in_valid,
        input  in_a,
        input  in_b,
        input  in_oper,
        input  in_tag,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_sum,
        output out_oper,
        output out_tag
    );
endinterface

// File: rtl/alu64_dispatch_stage.sv
// Issue stage for the 64-bit combinational ALU: request FIFO + result slot.
// Define ALU_DISPATCH_FLAGS_EN to add registered out_zero/out_neg flags.
module alu64_dispatch_stage #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    alu64_dispatch_stage_if.slave io,
    output logic [63:0]           alu_a,
    output logic [63:0]           alu_b,
    output logic [2:0]            alu_oper,
    input  logic [63:0]           alu_sum
`ifdef ALU_DISPATCH_FLAGS_EN
    ,
    output logic                  out_zero,
    output logic                  out_neg
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
    localparam logic [2:0] OP_ZERO = 3'b111;

    logic [63:0]      a_q    [DEPTH];
    logic [63:0]      b_q    [DEPTH];
    logic [2:0]       oper_q [DEPTH];
    logic [TAG_W-1:0] tag_q  [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic             out_valid_q;
    logic [63:0]      out_sum_q;
    logic [2:0]       out_oper_q;
    logic [TAG_W-1:0] out_tag_q;

    logic empty;
    logic push;
    logic issue;
    logic drop;

    assign empty = (count == '0);
    // Ready comes from the registered count only, so a pop never opens the
    // input in the same cycle.
    assign io.in_ready = (count != FULL);
    assign push = io.in_valid & io.in_ready;
    assign issue = !empty & (!out_valid_q | io.out_ready);
    assign drop = out_valid_q & io.out_ready & !issue;

    // Storage is not reset; the pointers and count define what is live.
    always_ff @(posedge clk) begin
        if (push) begin
            a_q[wr_ptr]    <= io.in_a;
            b_q[wr_ptr]    <= io.in_b;
            oper_q[wr_ptr] <= io.in_oper;
            tag_q[wr_ptr]  <= io.in_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (issue) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, issue})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // An empty FIFO presents a neutral zero op to the ALU.
    always_comb begin
        alu_a    = '0;
        alu_b    = '0;
        alu_oper = OP_ZERO;
        if (!empty) begin
            alu_a    = a_q[rd_ptr];
            alu_b    = b_q[rd_ptr];
            alu_oper = oper_q[rd_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_oper_q  <= '0;
            out_tag_q   <= '0;
        end else if (issue) begin
            out_valid_q <= 1'b1;
            out_sum_q   <= alu_sum;
            out_oper_q  <= oper_q[rd_ptr];
            out_tag_q   <= tag_q[rd_ptr];
        end else if (drop) begin
            out_valid_q <= 1'b0;
        end
    end

`ifdef ALU_DISPATCH_FLAGS_EN
    logic zero_q;
    logic neg_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
        end else if (issue) begin
            zero_q <= (alu_sum == 64'd0);
            neg_q  <= alu_sum[63];
        end
    end

    assign out_zero = zero_q;
    assign out_neg  = neg_q;
`endif

    assign io.out_valid = out_valid_q;
    assign io.out_sum   = out_sum_q;
    assign io.out_oper  = out_oper_q;
    assign io.out_tag   = out_tag_q;

endmodule
